// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake stream master.
package hs_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;   // taps 8,6,5,4

    // Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/hs_stream_master_if.sv
// Valid/ready stream bundle between the test master and its sink.
interface hs_stream_master_if #(
    parameter int DATA_W = 3
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/hs_pattern_table.sv
// Pattern register file: async read, sync write, async reset to index defaults.
// Write addresses that do not match an entry fall through without effect.
module hs_pattern_table #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 5,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    // Reset loads table[i] = i mod 2**DATA_W; writes hit only a matching entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++)
                if (waddr == ADDR_W'(i)) mem[i] <= wdata;
        end
    end

    // Mux read without indexing past DEPTH for non-power-of-two tables.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++)
            if (raddr == ADDR_W'(i)) rdata = mem[i];
    end

endmodule

// File: rtl/hs_stream_master.sv
// Burst stream source driving a valid/ready sink from a loadable pattern table.
// Optional macro HS_MASTER_THROTTLE_EN inserts LFSR-driven one-cycle bubbles
// after transfers; without it valid stays high for the whole burst.
module hs_stream_master
    import hs_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 5,
    parameter int LEN_W  = 8
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         burst_len,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    hs_stream_master_if.master       strm,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_W-1:0]         beat_cnt
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_e            state;
    logic [ADDR_W-1:0] idx;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic              done_q;
    logic              gap;
    logic              valid_i;
    logic              last_i;
    logic              xfer;
    logic              tbl_we;
    logic [DATA_W-1:0] rd_data;

    assign valid_i = (state == RUN) && !gap;
    assign last_i  = valid_i && (cnt == len_q - LEN_W'(1));
    assign xfer    = valid_i && strm.ready;
    // Table is frozen while a burst is running so the beat order is stable.
    assign tbl_we  = wr_en && (state == IDLE);

    hs_pattern_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk   (sys_clk),
        .rst   (rst),
        .we    (tbl_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx),
        .rdata (rd_data)
    );

`ifdef HS_MASTER_THROTTLE_EN
    logic [7:0] lfsr;
    logic       bubble;

    // Free-running pseudo-random source, stepped every cycle.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsr_next(lfsr);
    end

    // One idle cycle after a non-final transfer when lfsr[0] is set.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) bubble <= 1'b0;
        else     bubble <= xfer && !last_i && lfsr[0];
    end

    assign gap = bubble;
`else
    assign gap = 1'b0;
`endif

    // Burst FSM with beat/index counters and the end-of-burst done pulse.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        idx <= '0;
                        if (burst_len != '0) begin
                            len_q <= burst_len;
                            state <= RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        idx <= (idx == ADDR_W'(DEPTH - 1)) ? '0 : idx + ADDR_W'(1);
                        cnt <= cnt + LEN_W'(1);
                        if (last_i) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign strm.valid = valid_i;
    assign strm.last  = last_i;
    assign strm.data  = valid_i ? rd_data : '0;
    assign busy       = (state == RUN);
    assign done       = done_q;
    assign beat_cnt   = cnt;

endmodule
